codificador_instrucao: RTL and testbench
========================================

# codificador_instrucao

Registered RV64I instruction encoder. It is the inverse of the immediate extraction path: it takes decoded fields plus a 64-bit signed immediate and a format selector, checks that the immediate is representable in that format, and packs a 32-bit instruction word. Results are queued in a 2-entry output FIFO behind a valid/ready handshake, with a saturating error counter. It feeds instruction memory preload and self-test logic.

## Interface
- No parameters. Format codes (select_imm) are fixed: R=4'b0000, I=4'b0001, S=4'b0010, SB=4'b0011, U=4'b0100, UJ=4'b0101.
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- in_valid  input  1  request valid
- in_ready  output  1  encoder can accept a request
- select_imm  input  4  instruction format
- opcode  input  7  instr[6:0]
- rd  input  5  destination register
- rs1  input  5  source register 1
- rs2  input  5  source register 2
- funct3  input  3  funct3 field
- funct7  input  7  funct7 field; R only
- imm  input  64  signed immediate, byte offset for SB/UJ
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer takes the head entry
- out_instr  output  32  encoded instruction
- out_erro  output  1  immediate out of range, or illegal format
- n_erros  output  8  saturating count of accepted requests with erro=1

## Operation
- Accept when in_valid && in_ready. Pop when out_valid && out_ready.
- Encoding (fields not listed are ignored):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - SB: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - UJ: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Range checks use signed 64-bit comparison. erro=1 when a check fails:
  - I and S: imm must be in [-2048, 2047].
  - SB: imm must be in [-4096, 4094] and imm[0] must be 0.
  - UJ: imm must be in [-1048576, 1048574] and imm[0] must be 0.
  - U: imm[11:0] must be 0, and imm[63:31] must be all 0s or all 1s.
  - R never errs.
  - Any other select_imm value always errs.
- An errored entry is still queued, with instr=32'h0 and erro=1. It occupies a FIFO slot and keeps its order.
- n_erros increments on each accepted errored request. It saturates at 255.
- FIFO:
  - 2 entries, with a 2-bit count (0..2), write pointer and read pointer.
  - Order is strictly FIFO.
  - in_ready = (count != 2). It is registered-state only and never depends on out_ready.
  - Push and pop in the same cycle leave count unchanged. This can only happen at count=1, since push is blocked at count=2 and pop is impossible at count=0.

## Timing
- Reset values: count=0, pointers=0, out_valid=0, in_ready=1, n_erros=0. Stored entries are cleared to 0.
- reset takes effect immediately (asynchronous). Queued entries are discarded, and an in-flight acceptance in that cycle is lost.
- Latency: a request accepted at edge N appears at out_valid/out_instr after edge N. That is 1 cycle when the FIFO is empty.
- out_instr and out_erro are driven from the head entry. They are 0 whenever out_valid=0.
- Throughput: 1 request/cycle while out_ready=1.
- out_valid = (count != 0).
- Full: count=2 gives in_ready=0. in_ready returns to 1 the cycle after a pop.

## Test plan
- addi x1,x0,5: I, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 -> out_instr=0x00500093, out_erro=0, out_valid one cycle after accept.
- sw x5,-4(x2): S, opcode=0x23, funct3=2, rs1=2, rs2=5, imm=-4 -> 0xFE512E23. jal x1,+2048: UJ, opcode=0x6F, rd=1, imm=0x800 -> 0x001000EF.
- Range errors:
  - SB imm=3 -> erro=1, instr=0.
  - I imm=2048 -> erro=1.
  - I imm=-2048 -> erro=0, instr[31:20]=0x800.
  - select_imm=4'b0111 -> erro=1.
  - n_erros reaches 3.
  - After 300 errored requests, n_erros=255.
- Backpressure: out_ready=0, issue 3 back-to-back requests -> first two accepted, in_ready=0 from the cycle after the second. Raise out_ready -> all three emerge in order, one per cycle.
- Concurrent push/pop at count=1 with out_ready=1 and in_valid=1 held -> count stays 1, with no loss or duplication over 10 requests.
- Reset mid-operation: 2 entries queued, pulse reset between edges -> out_valid=0 and in_ready=1 immediately, n_erros=0. Nothing from before the reset is emitted afterwards.

Source files
------------

// File: rtl/codificador_instrucao.sv
`default_nettype none
// ============================================================================
// Module   : codificador_instrucao
// Purpose  : Registered RV64I instruction encoder. Takes decoded fields, a
//            64-bit signed immediate and a format selector, checks that the
//            immediate fits the format, and packs a 32-bit instruction word.
//            Results go into a 2-entry FIFO with a valid/ready handshake.
//            A saturating counter tracks accepted requests that errored.
// Ports    : clk, reset (async, active-high)
//            in_valid / in_ready          - request handshake
//            select_imm, opcode, rd, rs1, rs2, funct3, funct7, imm
//                                         - decoded request fields
//            out_valid / out_ready        - result handshake
//            out_instr, out_erro          - head FIFO entry (0 when empty)
//            n_erros                      - saturating error count
// Revision : 1.0 - initial release
// ============================================================================
module codificador_instrucao (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  select_imm,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [63:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_erro,
    output logic [7:0]  n_erros
);

    localparam logic [3:0] c_FMT_R  = 4'b0000;
    localparam logic [3:0] c_FMT_I  = 4'b0001;
    localparam logic [3:0] c_FMT_S  = 4'b0010;
    localparam logic [3:0] c_FMT_SB = 4'b0011;
    localparam logic [3:0] c_FMT_U  = 4'b0100;
    localparam logic [3:0] c_FMT_UJ = 4'b0101;

    localparam logic [1:0] c_DEPTH  = 2'd2;
    localparam logic [7:0] c_ERR_MAX = 8'hFF;

    // ------------------------------------------------------------------
    // Encoder and range check
    // ------------------------------------------------------------------
    logic signed [63:0] w_imm_s;
    logic [31:0]        w_enc;
    logic               w_erro;
    logic [31:0]        w_entry_instr;

    assign w_imm_s = imm;

    always_comb begin
        w_enc  = '0;
        w_erro = 1'b0;
        case (select_imm)
            c_FMT_R: begin
                w_enc = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            c_FMT_I: begin
                w_enc  = {imm[11:0], rs1, funct3, rd, opcode};
                w_erro = (w_imm_s < -64'sd2048) || (w_imm_s > 64'sd2047);
            end
            c_FMT_S: begin
                w_enc  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                w_erro = (w_imm_s < -64'sd2048) || (w_imm_s > 64'sd2047);
            end
            c_FMT_SB: begin
                w_enc  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1],
                          imm[11], opcode};
                w_erro = (w_imm_s < -64'sd4096) || (w_imm_s > 64'sd4094) ||
                         imm[0];
            end
            c_FMT_U: begin
                w_enc  = {imm[31:12], rd, opcode};
                // Upper bits must be a pure sign extension of bit 31.
                w_erro = (imm[11:0] != 12'h000) ||
                         !((imm[63:31] == '0) || (imm[63:31] == '1));
            end
            c_FMT_UJ: begin
                w_enc  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                w_erro = (w_imm_s < -64'sd1048576) ||
                         (w_imm_s > 64'sd1048574) || imm[0];
            end
            default: begin
                w_erro = 1'b1;
            end
        endcase
    end

    // Errored entries are stored with a zero instruction word.
    assign w_entry_instr = w_erro ? 32'h0 : w_enc;

    // ------------------------------------------------------------------
    // 2-entry FIFO
    // ------------------------------------------------------------------
    logic [31:0] r_mem_instr [0:1];
    logic        r_mem_erro  [0:1];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic [7:0]  r_n_erros;
    logic        w_push;
    logic        w_pop;

    // in_ready is derived from stored state only, so a full FIFO never
    // accepts in the same cycle it is being drained.
    assign in_ready  = (r_count != c_DEPTH);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign out_instr = out_valid ? r_mem_instr[r_rd_ptr] : 32'h0;
    assign out_erro  = out_valid ? r_mem_erro[r_rd_ptr]  : 1'b0;
    assign n_erros   = r_n_erros;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count        <= 2'd0;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_n_erros      <= 8'd0;
            r_mem_instr[0] <= 32'h0;
            r_mem_instr[1] <= 32'h0;
            r_mem_erro[0]  <= 1'b0;
            r_mem_erro[1]  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem_instr[r_wr_ptr] <= w_entry_instr;
                r_mem_erro[r_wr_ptr]  <= w_erro;
                r_wr_ptr              <= ~r_wr_ptr;
                if (w_erro && (r_n_erros != c_ERR_MAX)) begin
                    r_n_erros <= r_n_erros + 8'd1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_codificador_instrucao.sv
`default_nettype none
// ============================================================================
// Module   : tb_codificador_instrucao
// Purpose  : Self-checking bench for codificador_instrucao. A queue-based
//            reference model predicts the FIFO contents; the encoding and
//            range rules are computed from plain integer arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_codificador_instrucao;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  select_imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_erro;
    logic [7:0]  n_erros;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] q[$];      // {erro, instr} entries in FIFO order
    int          m_nerr;

    longint c_bnd [0:19] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094,
                             4095, 4096, -1048577, -1048576, 1048574,
                             1048575, 1048576, 64'h7FFFF000,
                             -64'sd2147483648, 64'h80000000, -4096,
                             64'hFFFFFFFF00000000, 0};

    codificador_instrucao u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .select_imm (select_imm),
        .opcode     (opcode),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .funct3     (funct3),
        .funct7     (funct7),
        .imm        (imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_erro   (out_erro),
        .n_erros    (n_erros)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference encoder: returns {erro, instr}.
    function automatic logic [32:0] ref_enc(input logic [3:0] fmt,
            input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
            input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
            input longint v);
        longint lop, ld, ls1, ls2, lf3, lf7, w;
        bit bad;
        lop = longint'(op);  ld  = longint'(d);
        ls1 = longint'(s1);  ls2 = longint'(s2);
        lf3 = longint'(f3);  lf7 = longint'(f7);
        w   = 0;
        bad = 1'b0;
        case (fmt)
            4'd0: w = (lf7 << 25) | (ls2 << 20) | (ls1 << 15) | (lf3 << 12) |
                      (ld << 7) | lop;
            4'd1: begin
                bad = (v < -2048) || (v > 2047);
                w = ((v & 'hFFF) << 20) | (ls1 << 15) | (lf3 << 12) |
                    (ld << 7) | lop;
            end
            4'd2: begin
                bad = (v < -2048) || (v > 2047);
                w = (((v >>> 5) & 'h7F) << 25) | (ls2 << 20) | (ls1 << 15) |
                    (lf3 << 12) | ((v & 'h1F) << 7) | lop;
            end
            4'd3: begin
                bad = (v < -4096) || (v > 4094) || ((v & 1) != 0);
                w = (((v >>> 12) & 1) << 31) | (((v >>> 5) & 'h3F) << 25) |
                    (ls2 << 20) | (ls1 << 15) | (lf3 << 12) |
                    (((v >>> 1) & 'hF) << 8) | (((v >>> 11) & 1) << 7) | lop;
            end
            4'd4: begin
                bad = ((v & 'hFFF) != 0) || (v < -64'sd2147483648) ||
                      (v > 64'sd2147483647);
                w = (v & 'hFFFFF000) | (ld << 7) | lop;
            end
            4'd5: begin
                bad = (v < -1048576) || (v > 1048574) || ((v & 1) != 0);
                w = (((v >>> 20) & 1) << 31) | (((v >>> 1) & 'h3FF) << 21) |
                    (((v >>> 11) & 1) << 20) | (((v >>> 12) & 'hFF) << 12) |
                    (ld << 7) | lop;
            end
            default: bad = 1'b1;
        endcase
        return bad ? {1'b1, 32'h0} : {1'b0, w[31:0]};
    endfunction

    // One clock cycle: check outputs against the model, then advance both.
    task automatic cycle();
        logic [32:0] head;
        logic [32:0] ent;
        logic [32:0] dropped;
        bit acc, pop;
        head = (q.size() != 0) ? q[0] : 33'h0;
        chk("in_ready",  64'(in_ready),  64'(q.size() != 2));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("out_instr", 64'(out_instr), 64'(head[31:0]));
        chk("out_erro",  64'(out_erro),  64'(head[32]));
        chk("n_erros",   64'(n_erros),   64'(m_nerr));
        acc = in_valid && (q.size() != 2);
        pop = (q.size() != 0) && out_ready;
        ent = ref_enc(select_imm, opcode, rd, rs1, rs2, funct3, funct7,
                      longint'(imm));
        @(posedge clk);
        if (pop) dropped = q.pop_front();
        if (acc) begin
            q.push_back(ent);
            if (ent[32] && m_nerr < 255) m_nerr++;
        end
        @(negedge clk);
    endtask

    task automatic req(input logic [3:0] f, input logic [6:0] op,
                       input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3,
                       input logic [6:0] f7, input longint v);
        in_valid = 1'b1; select_imm = f; opcode = op; rd = d; rs1 = s1;
        rs2 = s2; funct3 = f3; funct7 = f7; imm = v;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    function automatic longint pick_imm();
        case ($urandom_range(0, 5))
            0: return longint'($urandom_range(0, 10000)) - 5000;
            1: return c_bnd[$urandom_range(0, 19)];
            2: return {$urandom, $urandom};
            3: return longint'($urandom_range(0, 4194304)) - 2097152;
            4: return longint'(int'($urandom & 32'hFFFFF000));
            default: return c_bnd[$urandom_range(0, 19)] +
                            longint'($urandom_range(0, 2)) - 1;
        endcase
    endfunction

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        select_imm = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
        funct3 = '0; funct7 = '0; imm = '0;
        m_nerr = 0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_n_erros",   64'(n_erros),   64'd0);
        reset = 1'b0;
        out_ready = 1'b1;

        // addi x1,x0,5
        req(4'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 5);
        cycle(); idle();
        chk("addi", 64'(out_instr), 64'h00500093);
        chk("addi_valid", 64'(out_valid), 64'd1);
        cycle();
        // sw x5,-4(x2)
        req(4'd2, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, -4);
        cycle(); idle();
        chk("sw", 64'(out_instr), 64'hFE512E23);
        cycle();
        // jal x1,+2048
        req(4'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 'h800);
        cycle(); idle();
        chk("jal", 64'(out_instr), 64'h001000EF);
        cycle();
        // range errors
        req(4'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 3);
        cycle(); idle();
        chk("sb_odd_erro", 64'(out_erro), 64'd1);
        chk("sb_odd_instr", 64'(out_instr), 64'd0);
        cycle();
        req(4'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 2048);
        cycle(); idle();
        chk("i_2048_erro", 64'(out_erro), 64'd1);
        cycle();
        req(4'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -2048);
        cycle(); idle();
        chk("i_m2048_erro", 64'(out_erro), 64'd0);
        chk("i_m2048_imm", 64'(out_instr[31:20]), 64'h800);
        cycle();
        req(4'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 0);
        cycle(); idle();
        chk("fmt7_erro", 64'(out_erro), 64'd1);
        chk("n_erros_3", 64'(n_erros), 64'd3);
        cycle();

        // Backpressure: three back-to-back requests with consumer stalled.
        out_ready = 1'b0;
        req(4'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1); cycle();
        req(4'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 2); cycle();
        chk("bp_full", 64'(in_ready), 64'd0);
        req(4'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 3); cycle();
        out_ready = 1'b1;
        chk("bp_head", 64'(out_instr), 64'h00100093);
        cycle();
        chk("bp_second", 64'(out_instr), 64'h00200113);
        cycle(); idle();
        chk("bp_third", 64'(out_instr), 64'h00300193);
        cycle();
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Concurrent push/pop at count=1.
        for (int i = 0; i < 10; i++) begin
            req(4'd0, 7'h33, 5'(i), 5'(i + 1), 5'(i + 2), 3'd0, 7'd0, 0);
            cycle();
        end
        idle(); cycle();
        chk("pp_drained", 64'(out_valid), 64'd0);

        // Reset mid-operation with two entries queued.
        out_ready = 1'b0;
        req(4'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 4); cycle();
        req(4'd7, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 0); cycle();
        idle();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
        chk("mid_rst_n_erros",   64'(n_erros),   64'd0);
        reset = 1'b0;
        q.delete();
        m_nerr = 0;
        @(negedge clk);
        out_ready = 1'b1;
        repeat (3) cycle();

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++) begin
            req(4'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 0);
            cycle();
        end
        idle(); cycle();
        chk("n_erros_sat", 64'(n_erros), 64'd255);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            out_ready  = ($urandom_range(0, 9) < 6);
            select_imm = ($urandom_range(0, 19) == 0) ? 4'hF
                                                      : 4'($urandom_range(0, 7));
            opcode = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom);
            rs2 = 5'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
            imm = pick_imm();
            cycle();
        end
        idle(); out_ready = 1'b1;
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
